fb_reader: RTL

//  Wishbone read master that fetches the 16-bit RGB565 framebuffer from SDRAM in raster

---
 rtl/fb_pkg.sv | 18 +
 rtl/fb_fifo.sv | 55 +++++
 rtl/fb_reader.sv | 133 +++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared types for the framebuffer reader.
//   pixel_t      : one RGB565 pixel
//   fifo_entry_t : pixel plus start-of-frame / end-of-line markers
//   rd_state_e   : bus request / fair-play states of the reader
package fb_pkg;
  localparam int HDISP_DEF = 640;
  localparam int VDISP_DEF = 480;

  typedef logic [15:0] pixel_t;

  typedef struct packed {
    logic   sof;
    logic   eol;
    pixel_t pix;
  } fifo_entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RELEASE} rd_state_e;
endpackage

// File: rtl/fb_fifo.sv
// First-word-fall-through FIFO of fifo_entry_t.
//   clk, rst_n : clock, async active-low reset
//   flush_i    : empties the FIFO on the next edge (wins over push/pop)
//   push_i     : write din_i
//   pop_i      : drop the head entry (ignored when empty)
//   dout_o     : head entry, valid whenever !empty_o
//   empty_o    : no entries
//   level_o    : occupancy 0..DEPTH
module fb_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fifo_entry_t                din_i,
  input  logic                       pop_i,
  output fifo_entry_t                dout_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int AW = $clog2(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  logic [AW:0]   wr_q, rd_q;
  logic          full;

  // One extra pointer bit distinguishes full from empty.
  assign level_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign full    = (level_o == (AW+1)'(DEPTH));
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i)            wr_q <= wr_q + 1'b1;
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

  // The reader only requests while there is room, so a push into a full FIFO is a design bug.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full));
endmodule

// File: rtl/fb_reader.sv
// Wishbone read master streaming the RGB565 framebuffer in raster order.
//   clk, rst_n          : clock, async active-low reset
//   wb_adr/cyc/stb      : classic single-beat read request, adr = BASE + 2*(HDISP*y + x)
//   wb_we/sel/cti/bte   : constant read, both bytes, classic, linear
//   wb_dat_sm, wb_ack   : read data and acknowledge
//   resync              : flush and restart at pixel (0,0)
//   pix_data/sof/eol    : FIFO head pixel with frame / line markers
//   pix_valid/pix_ready : stream handshake
//   fifo_level          : FIFO occupancy
module fb_reader
  import fb_pkg::*;
#(
  parameter int          HDISP      = HDISP_DEF,
  parameter int          VDISP      = VDISP_DEF,
  parameter logic [31:0] BASE_ADR   = 32'h0,
  parameter int          FIFO_DEPTH = 256,
  parameter int          FAIR_LEN   = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic [31:0]                   wb_adr,
  output logic                          wb_cyc,
  output logic                          wb_stb,
  output logic                          wb_we,
  output logic [1:0]                    wb_sel,
  output logic [2:0]                    wb_cti,
  output logic [1:0]                    wb_bte,
  input  logic [15:0]                   wb_dat_sm,
  input  logic                          wb_ack,
  input  logic                          resync,
  output logic [15:0]                   pix_data,
  output logic                          pix_sof,
  output logic                          pix_eol,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int FW = $clog2(FAIR_LEN + 1);

  rd_state_e   state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [FW-1:0] fair_q, fair_d;

  logic        ack_ok, pop, empty, last_x, last_y, fair_hit, room;
  logic [LW-1:0] lvl_nxt;
  fifo_entry_t push_ent, head;

  // An ack only counts while we are strobing, and never in a resync cycle.
  assign ack_ok   = wb_ack && (state_q == ST_REQ) && !resync;
  assign pop      = pix_valid && pix_ready;
  assign last_x   = (x_q == XW'(HDISP - 1));
  assign last_y   = (y_q == YW'(VDISP - 1));
  assign fair_hit = (fair_q == FW'(FAIR_LEN - 1));
  // Room is judged on the occupancy after this cycle's push/pop, so a request
  // is only ever outstanding when its data is guaranteed a slot.
  assign lvl_nxt  = fifo_level + LW'(ack_ok) - LW'(pop);
  assign room     = (lvl_nxt < LW'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    fair_d  = fair_q;
    if (resync) begin
      state_d = ST_IDLE;
      x_d     = '0;
      y_d     = '0;
      fair_d  = '0;
    end else begin
      if (ack_ok) begin
        if (last_x) begin
          x_d = '0;
          y_d = last_y ? '0 : y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
        fair_d = fair_hit ? '0 : fair_q + 1'b1;
      end
      case (state_q)
        ST_IDLE:    if (room) state_d = ST_REQ;
        ST_REQ:     if (ack_ok) state_d = fair_hit ? ST_RELEASE : (room ? ST_REQ : ST_IDLE);
        ST_RELEASE: state_d = room ? ST_REQ : ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      fair_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fair_q  <= fair_d;
    end
  end

  assign wb_cyc = (state_q == ST_REQ);
  assign wb_stb = (state_q == ST_REQ);
  assign wb_we  = 1'b0;
  assign wb_sel = 2'b11;
  assign wb_cti = 3'b000;
  assign wb_bte = 2'b00;
  assign wb_adr = BASE_ADR + ((32'(HDISP) * 32'(y_q) + 32'(x_q)) << 1);

  assign push_ent = '{sof: (x_q == '0) && (y_q == '0), eol: last_x, pix: wb_dat_sm};

  fb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush_i(resync),
    .push_i (ack_ok),
    .din_i  (push_ent),
    .pop_i  (pop),
    .dout_o (head),
    .empty_o(empty),
    .level_o(fifo_level)
  );

  // Head is masked while empty so the stream idles at all-zero.
  assign pix_valid = !empty;
  assign pix_data  = pix_valid ? head.pix : '0;
  assign pix_sof   = pix_valid && head.sof;
  assign pix_eol   = pix_valid && head.eol;
endmodule
